// File: rtl/nvm_pkg.sv
// nvm_pkg: shared constants and the FIFO entry layout for the NVM serial receive path.
package nvm_pkg;

  // Address width driven by the NVM serial reader.
  localparam int NVM_AW = 5;
  // Bits per serial frame.
  localparam int NVM_DW = 8;
  // Width of the per-byte bit counter.
  localparam int NVM_CNT_W = $clog2(NVM_DW);

  // One buffered byte together with the address sampled on its first bit.
  typedef struct packed {
    logic [NVM_AW-1:0] addr;
    logic [NVM_DW-1:0] data;
  } nvm_rx_entry_t;

endpackage

// File: rtl/nvm_rx_fifo.sv
// nvm_rx_fifo: small synchronous FIFO with a combinational head.
// A push into a full FIFO is accepted only if a pop happens on the same edge;
// otherwise it is dropped and drop_o pulses. A pop while empty is ignored.
module nvm_rx_fifo
  import nvm_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = nvm_rx_entry_t
) (
  input  logic   clk,
  input  logic   clr,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output logic   valid_o,
  output entry_t head_o,
  output logic   drop_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_q;
  logic [OW-1:0] occ_q;
  entry_t        mem_q [DEPTH];

  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;

  // Qualify push/pop against occupancy; a same-edge pop frees the slot a full push needs.
  always_comb begin
    empty_s = (occ_q == '0);
    full_s  = (occ_q == OW'(DEPTH));
    pop_s   = pop_i & ~empty_s;
    push_s  = push_i & (~full_s | pop_s);
    drop_o  = push_i & full_s & ~pop_s;
  end

  assign valid_o = ~empty_s;
  assign head_o  = mem_q[rptr_q];

  // Storage, pointers (power-of-two depth, natural wrap) and occupancy.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/nvm_sipo_rx.sv
// nvm_sipo_rx: deserializes the MSB-first NVM bit stream into bytes, tags each
// byte with the address seen on its first bit, and buffers them for the bus side.
// Optional build macro NVM_RX_ERRCNT_EN adds an 8-bit saturating dropped-byte counter.
// AW/DW must match the nvm_rx_entry_t layout in nvm_pkg.
module nvm_sipo_rx
  import nvm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = NVM_AW,
  parameter int DW    = NVM_DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          frame,
  input  logic          ser_valid,
  input  logic          ser_data,
  input  logic [AW-1:0] addr_in,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic [DW-1:0] byte_data,
  output logic [AW-1:0] byte_addr,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          busy
`ifdef NVM_RX_ERRCNT_EN
  ,output logic [7:0]   ovf_count
`endif
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ovf_q, ovf_d;

  logic          last_s;
  logic          drop_s;
  nvm_rx_entry_t push_entry_s;
  nvm_rx_entry_t head_s;

  // The eighth accepted bit completes a byte; it goes to the FIFO on the same edge.
  always_comb begin
    last_s            = frame & ser_valid & (cnt_q == CW'(DW - 1));
    push_entry_s.addr = addr_q;
    push_entry_s.data = {shift_q[DW-2:0], ser_data};
  end

  // Deserializer next state: frame low aborts the partial byte ahead of any bit.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if (!frame) begin
      cnt_d = '0;
    end else if (ser_valid) begin
      shift_d = {shift_q[DW-2:0], ser_data};
      if (cnt_q == '0) begin
        addr_d = addr_in;
      end else begin
        addr_d = addr_q;
      end
      if (cnt_q == CW'(DW - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sticky overflow: a drop on the same edge as a clear leaves the flag set.
  always_comb begin
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Deserializer, address latch and overflow registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

  nvm_rx_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (nvm_rx_entry_t)
  ) u_fifo (
    .clk         (clk),
    .clr         (clr),
    .push_i      (last_s),
    .push_data_i (push_entry_s),
    .pop_i       (byte_ready),
    .valid_o     (byte_valid),
    .head_o      (head_s),
    .drop_o      (drop_s)
  );

  assign byte_data = head_s.data;
  assign byte_addr = head_s.addr;
  assign ovf       = ovf_q;
  assign busy      = (cnt_q != '0);

`ifdef NVM_RX_ERRCNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-byte counter: saturates at 255; a drop during a clear restarts at 1.
  always_comb begin
    if (drop_s) begin
      if (ovf_clr) begin
        ovf_cnt_d = 8'd1;
      end else if (ovf_cnt_q == 8'd255) begin
        ovf_cnt_d = 8'd255;
      end else begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_cnt_d = 8'd0;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Dropped-byte counter register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: doc/nvm_sipo_rx.md
Name: nvm_sipo_rx

Overview:
- Downstream consumer of the NVM serial reader.
- Samples the MSB-first serial bit stream and the accompanying 5-bit address, and reassembles 8-bit bytes.
- Buffers completed bytes in a small FIFO and presents them to the system bus side with a valid/ready handshake.
- Detects and flags overflow when the consumer stalls.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- AW, 5, address width; matches the serial reader's address output.
- DW, 8, byte width; bits per serial frame.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous active-low reset.
- frame  in  1  high while a serial read is in progress; low discards any partial byte.
- ser_valid  in  1  qualifies ser_data this cycle.
- ser_data  in  1  serial bit, MSB first.
- addr_in  in  AW  address accompanying the current byte.
- byte_valid  out  1  FIFO head holds a byte.
- byte_ready  in  1  consumer accepts the head this cycle.
- byte_data  out  DW  head byte.
- byte_addr  out  AW  address captured with the head byte's first bit.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.
- busy  out  1  partial byte in progress (bit count != 0).

Behaviour:
- Reset (clr=0, async): shift register, bit count, FIFO pointers, occupancy and ovf all go to 0. Therefore byte_valid=0, busy=0, byte_data=0, byte_addr=0.
- Bit sampling: a bit is accepted on a rising edge where frame=1 and ser_valid=1.
  - shift <= {shift[DW-2:0], ser_data}
  - bit count increments.
- Address capture: on the accepted bit with count=0, addr_in is latched as the byte address.
- Abort: frame=0 forces bit count to 0 on the next edge and discards the partial byte. This takes priority over ser_valid. No FIFO write and no ovf.
- Byte completion: the accepted bit with count=DW-1 forms {shift[DW-2:0], ser_data}.
  - The byte and its latched address are written to the FIFO on that same edge.
  - Count wraps to 0.
  - byte_valid is visible the cycle after that edge; latency is 1 cycle from the last bit.
- FIFO:
  - Head is shown combinationally from storage at the read pointer.
  - Pop occurs on an edge where byte_valid=1 and byte_ready=1.
  - byte_ready while empty is ignored.
  - Pointers are log2(DEPTH) bits wide and wrap. Occupancy counter spans 0..DEPTH.
- Full plus push, no pop: the byte is dropped, FIFO contents are unchanged, ovf is set to 1.
- Full plus push plus pop on the same edge: push is accepted, occupancy stays DEPTH, ovf is unchanged.
- Empty plus push plus pop: the pop is ignored; occupancy becomes 1.
- ovf:
  - Sticky until ovf_clr=1.
  - If ovf_clr and a new overflow fall on the same edge, ovf ends at 1 (set wins).
- busy: equals (count != 0).
- No state machine beyond count/FIFO. The receiver is always ready; it never back-pressures the serial side.

Optional Feature:
- Macro: NVM_RX_ERRCNT_EN.
- Defined:
  - Adds output ovf_count, 8 bits.
  - It increments on every dropped byte and saturates at 255.
  - It clears on ovf_clr. If ovf_clr and a drop fall on the same edge, the result is 1.
  - Reset value is 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package nvm_pkg holds:
  - NVM_AW=5 and NVM_DW=8.
  - The bit-count width constant, clog2(NVM_DW).
  - A packed struct/typedef nvm_rx_entry_t = {addr[AW-1:0], data[DW-1:0]}, used for FIFO storage.
- One natural sub-module: nvm_rx_fifo, a generic synchronous FIFO with push, pop, full, empty and overflow-drop semantics as specified above.
- The top level holds the deserializer, the address latch and ovf.

Test Plan:
- Byte assembly: reset; frame=1, ser_valid=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 and addr_in=5'h13 on the first bit -> one cycle after the 8th bit, byte_valid=1, byte_data=8'hA5, byte_addr=5'h13. With byte_ready=1, byte_valid=0 the next cycle.
- Gapped bits: the same 8'h3C stream with ser_valid low on alternate cycles -> byte_data=8'h3C; busy=1 from the 1st to the 7th accepted bit.
- Abort: 5 bits of 8'hFF, then frame=0 for 1 cycle, then a full 8'h81 -> exactly one FIFO entry, byte_data=8'h81, ovf=0.
- Overflow: byte_ready=0; send 3 bytes 8'h11, 8'h22, 8'h33 with DEPTH=2 -> ovf=1; draining yields 8'h11 then 8'h22 only. With NVM_RX_ERRCNT_EN, ovf_count=1. Pulse ovf_clr -> ovf=0.
- Full with simultaneous pop: FIFO full (8'h11, 8'h22); complete 8'h33 on the same edge as byte_ready=1 -> ovf=0, drain order is 8'h22, 8'h33.
- Async reset mid-byte: after 4 bits and with one FIFO entry, drop clr between clock edges -> byte_valid=0 and busy=0 immediately. After release, a fresh 8'hC3 is received correctly.
